// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and
// load/store. One transaction at a time: IDLE (grant) -> BUSY (wait ack) -> RESP (ack pulse).
module core_mem_arbiter #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [XLEN-1:0] i_instr_addr,
    input  logic            i_instr_req,
    output logic [XLEN-1:0] o_instr_data,
    output logic            o_instr_ack,
    input  logic [XLEN-1:0] i_data_addr,
    input  logic [XLEN-1:0] i_data_wr_data,
    input  logic [1:0]      i_data_mask,
    input  logic            i_data_wr_en,
    input  logic            i_data_req,
    output logic [XLEN-1:0] o_data_rd_data,
    output logic            o_data_ack,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wr_data,
    output logic [1:0]      o_mem_mask,
    output logic            o_mem_wr_en,
    output logic            o_mem_req,
    input  logic [XLEN-1:0] i_mem_rd_data,
    input  logic            i_mem_ack,
    output logic            o_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t            state_q, state_d;
    logic              last_gnt_q, last_gnt_d;  // 1 = data side granted last
    logic              gnt_data_q, gnt_data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wr_data_q, mem_wr_data_d;
    logic [1:0]        mem_mask_q, mem_mask_d;
    logic              mem_wr_en_q, mem_wr_en_d;
    logic              mem_req_q, mem_req_d;
    logic [XLEN-1:0]   instr_data_q, instr_data_d;
    logic              instr_ack_q, instr_ack_d;
    logic [XLEN-1:0]   data_rd_data_q, data_rd_data_d;
    logic              data_ack_q, data_ack_d;
    logic              err_q, err_d;

    logic any_req, pick_data, timeout;

    // On a tie the side that did not win last time goes first.
    assign any_req   = i_instr_req | i_data_req;
    assign pick_data = i_data_req & (~i_instr_req | ~last_gnt_q);
    assign timeout   = (cnt_q >= CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q        <= S_IDLE;
            last_gnt_q     <= 1'b1;
            gnt_data_q     <= 1'b0;
            cnt_q          <= '0;
            mem_addr_q     <= '0;
            mem_wr_data_q  <= '0;
            mem_mask_q     <= '0;
            mem_wr_en_q    <= 1'b0;
            mem_req_q      <= 1'b0;
            instr_data_q   <= '0;
            instr_ack_q    <= 1'b0;
            data_rd_data_q <= '0;
            data_ack_q     <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_gnt_q     <= last_gnt_d;
            gnt_data_q     <= gnt_data_d;
            cnt_q          <= cnt_d;
            mem_addr_q     <= mem_addr_d;
            mem_wr_data_q  <= mem_wr_data_d;
            mem_mask_q     <= mem_mask_d;
            mem_wr_en_q    <= mem_wr_en_d;
            mem_req_q      <= mem_req_d;
            instr_data_q   <= instr_data_d;
            instr_ack_q    <= instr_ack_d;
            data_rd_data_q <= data_rd_data_d;
            data_ack_q     <= data_ack_d;
            err_q          <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_req) state_d = S_BUSY;
            S_BUSY:  if (i_mem_ack || timeout) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        last_gnt_d     = last_gnt_q;
        gnt_data_d     = gnt_data_q;
        cnt_d          = cnt_q;
        mem_addr_d     = mem_addr_q;
        mem_wr_data_d  = mem_wr_data_q;
        mem_mask_d     = mem_mask_q;
        mem_wr_en_d    = mem_wr_en_q;
        mem_req_d      = 1'b0;
        instr_data_d   = instr_data_q;
        instr_ack_d    = 1'b0;
        data_rd_data_d = data_rd_data_q;
        data_ack_d     = 1'b0;
        err_d          = err_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    gnt_data_d = pick_data;
                    last_gnt_d = pick_data;
                    mem_req_d  = 1'b1;
                    cnt_d      = '0;
                    if (pick_data) begin
                        mem_addr_d    = i_data_addr;
                        mem_wr_data_d = i_data_wr_data;
                        mem_mask_d    = i_data_mask;
                        mem_wr_en_d   = i_data_wr_en;
                    end else begin
                        mem_addr_d    = i_instr_addr;
                        mem_wr_data_d = '0;
                        mem_mask_d    = 2'd2;
                        mem_wr_en_d   = 1'b0;
                    end
                end
            end
            S_BUSY: begin
                if (i_mem_ack) begin
                    if (gnt_data_q) begin
                        data_rd_data_d = i_mem_rd_data;
                        data_ack_d     = 1'b1;
                    end else begin
                        instr_data_d = i_mem_rd_data;
                        instr_ack_d  = 1'b1;
                    end
                end else if (timeout) begin
                    // Abort still acks the requester so the core cannot stall forever.
                    err_d = 1'b1;
                    if (gnt_data_q) begin
                        data_rd_data_d = '0;
                        data_ack_d     = 1'b1;
                    end else begin
                        instr_data_d = '0;
                        instr_ack_d  = 1'b1;
                    end
                end else begin
                    mem_req_d = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign o_instr_data   = instr_data_q;
    assign o_instr_ack    = instr_ack_q;
    assign o_data_rd_data = data_rd_data_q;
    assign o_data_ack     = data_ack_q;
    assign o_mem_addr     = mem_addr_q;
    assign o_mem_wr_data  = mem_wr_data_q;
    assign o_mem_mask     = mem_mask_q;
    assign o_mem_wr_en    = mem_wr_en_q;
    assign o_mem_req      = mem_req_q;
    assign o_err          = err_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter (TIMEOUT_CYCLES=4); every expectation is hand-derived.
module tb_core_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ia, da, dwd, mrd;
    logic [1:0]  dm;
    logic        ireq, dreq, dwe, mack;
    logic [31:0] instr_data, data_rd, mem_addr, mem_wd;
    logic [1:0]  mem_mask;
    logic        instr_ack, data_ack, mem_wr_en, mem_req, err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    core_mem_arbiter #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_instr_addr(ia), .i_instr_req(ireq),
        .o_instr_data(instr_data), .o_instr_ack(instr_ack),
        .i_data_addr(da), .i_data_wr_data(dwd), .i_data_mask(dm),
        .i_data_wr_en(dwe), .i_data_req(dreq),
        .o_data_rd_data(data_rd), .o_data_ack(data_ack),
        .o_mem_addr(mem_addr), .o_mem_wr_data(mem_wd), .o_mem_mask(mem_mask),
        .o_mem_wr_en(mem_wr_en), .o_mem_req(mem_req),
        .i_mem_rd_data(mrd), .i_mem_ack(mack), .o_err(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; ireq = 0; dreq = 0; dwe = 0; mack = 0;
        ia = '0; da = '0; dwd = '0; mrd = '0; dm = '0;
        tick(); tick();
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_iack", 32'(instr_ack), 0);
        chk("rst_dack", 32'(data_ack), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_mask", 32'(mem_mask), 0);
        chk("rst_idata", instr_data, 0);

        // single fetch, memory acks on the second BUSY cycle
        rst_n = 1; ireq = 1; ia = 32'h100;
        tick();
        chk("f1_req", 32'(mem_req), 1);
        chk("f1_addr", mem_addr, 32'h100);
        chk("f1_mask", 32'(mem_mask), 2);
        chk("f1_wen", 32'(mem_wr_en), 0);
        chk("f1_wd", mem_wd, 0);
        tick();
        chk("f1_req_busy", 32'(mem_req), 1);
        chk("f1_noack", 32'(instr_ack), 0);
        mack = 1; mrd = 32'h00500093;
        tick();
        chk("f1_iack", 32'(instr_ack), 1);
        chk("f1_idata", instr_data, 32'h00500093);
        chk("f1_dack", 32'(data_ack), 0);
        chk("f1_req_drop", 32'(mem_req), 0);
        mack = 0; ireq = 0;
        tick();
        chk("f1_iack_end", 32'(instr_ack), 0);
        tick();
        chk("f1_idle", 32'(mem_req), 0);

        // simultaneous fetch + store after reset: fetch wins the tie
        rst_n = 0; tick(); rst_n = 1;
        ireq = 1; ia = 32'h200;
        dreq = 1; da = 32'h1000; dwd = 32'hDEADBEEF; dm = 2; dwe = 1;
        tick();
        chk("t2_addr_i", mem_addr, 32'h200);
        chk("t2_wen_i", 32'(mem_wr_en), 0);
        chk("t2_wd_i", mem_wd, 0);
        mack = 1; mrd = 32'h11111111;
        tick();
        chk("t2_iack", 32'(instr_ack), 1);
        chk("t2_dack0", 32'(data_ack), 0);
        chk("t2_idata", instr_data, 32'h11111111);
        ireq = 0; mack = 0;
        tick();
        chk("t2_resp_iack", 32'(instr_ack), 0);
        chk("t2_resp_dack", 32'(data_ack), 0);
        tick();
        chk("t2_addr_d", mem_addr, 32'h1000);
        chk("t2_wen_d", 32'(mem_wr_en), 1);
        chk("t2_wd_d", mem_wd, 32'hDEADBEEF);
        chk("t2_mask_d", 32'(mem_mask), 2);
        chk("t2_req_d", 32'(mem_req), 1);
        mack = 1; mrd = 32'h22222222;
        tick();
        chk("t2_dack", 32'(data_ack), 1);
        chk("t2_iack1", 32'(instr_ack), 0);
        chk("t2_drd", data_rd, 32'h22222222);
        dreq = 0; mack = 0;
        tick();
        chk("t2_dack_end", 32'(data_ack), 0);

        // both held, immediate ack: I,D,I,D grants, acks 3 cycles apart
        ireq = 1; ia = 32'h300; dreq = 1; da = 32'h2000; dwe = 0; dm = 2;
        mack = 1; mrd = 32'hA5A5A5A5;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("alt_iack", 32'(instr_ack), 32'((k == 1) || (k == 7)));
            chk("alt_dack", 32'(data_ack), 32'((k == 4) || (k == 10)));
            if (k % 3 == 0)
                chk("alt_addr", mem_addr, (k % 6 == 0) ? 32'h300 : 32'h2000);
        end
        ireq = 0; dreq = 0; mack = 0;

        // load that never gets acked: abort after TIMEOUT_CYCLES
        dreq = 1; da = 32'h20; dm = 0; dwe = 0;
        tick();
        chk("to_req0", 32'(mem_req), 1);
        chk("to_mask", 32'(mem_mask), 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("to_req_hold", 32'(mem_req), 1);
            chk("to_noack", 32'(data_ack), 0);
        end
        tick();
        chk("to_req_drop", 32'(mem_req), 0);
        chk("to_dack", 32'(data_ack), 1);
        chk("to_drd", data_rd, 0);
        chk("to_err", 32'(err), 1);
        dreq = 0;
        tick();
        chk("to_dack_end", 32'(data_ack), 0);
        chk("to_err_sticky", 32'(err), 1);
        ireq = 1; ia = 32'h340;
        tick();
        chk("to_fetch_addr", mem_addr, 32'h340);
        mack = 1; mrd = 32'h12345678;
        tick();
        chk("to_fetch_ack", 32'(instr_ack), 1);
        chk("to_fetch_data", instr_data, 32'h12345678);
        chk("to_err_kept", 32'(err), 1);
        ireq = 0; mack = 0;
        tick();

        // reset during BUSY
        ireq = 1; ia = 32'h400;
        tick();
        chk("rb_req", 32'(mem_req), 1);
        rst_n = 0;
        tick();
        chk("rb_req_drop", 32'(mem_req), 0);
        chk("rb_iack", 32'(instr_ack), 0);
        chk("rb_dack", 32'(data_ack), 0);
        chk("rb_err", 32'(err), 0);
        rst_n = 1; dreq = 1; da = 32'h3000; dwe = 1; dwd = 32'h0BADF00D;
        tick();
        chk("rb_tie_addr", mem_addr, 32'h400);
        chk("rb_tie_wen", 32'(mem_wr_en), 0);
        mack = 1; mrd = 32'h55555555;
        tick();
        chk("rb_iack2", 32'(instr_ack), 1);
        chk("rb_idata", instr_data, 32'h55555555);
        ireq = 0; dreq = 0; mack = 0;
        tick();

        // spurious ack in IDLE, then request held through RESP
        mack = 1; mrd = 32'hFFFFFFFF;
        tick(); tick();
        chk("sp_iack", 32'(instr_ack), 0);
        chk("sp_dack", 32'(data_ack), 0);
        chk("sp_req", 32'(mem_req), 0);
        chk("sp_idata", instr_data, 32'h55555555);
        mack = 0; ireq = 1; ia = 32'h500;
        tick();
        chk("hr_req", 32'(mem_req), 1);
        mack = 1; mrd = 32'h66666666;
        tick();
        chk("hr_iack", 32'(instr_ack), 1);
        mack = 0;
        tick();
        chk("hr_resp_req", 32'(mem_req), 0);
        chk("hr_resp_iack", 32'(instr_ack), 0);
        ireq = 0;
        tick();
        chk("hr_no_regrant", 32'(mem_req), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
